// File: rtl/sram_responder_if.sv
// Instruction and data SRAM port bundle between the CPU (master) and the
// unified RAM responder (slave).
interface sram_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/sram_responder.sv
// Single-cycle unified RAM with byte-lane writes and read-first ports, plus a
// timer/LED/number register window decoded on the data port.
module sram_responder #(
  parameter int          ADDR_W  = 16,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic               clk,
  input  logic               resetn,
  sram_responder_if.slave    sram,
  output logic [15:0]        led_o,
  output logic [31:0]        num_o,
  output logic [31:0]        timer_o
);

  localparam int          DEPTH      = 2 ** ADDR_W;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF010;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  we);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [31:0]       inst_rdata_r;
  logic [31:0]       data_rdata_r;
  logic [31:0]       timer_r;
  logic [15:0]       led_r;
  logic [31:0]       num_r;

  logic [ADDR_W-1:0] inst_idx_s;
  logic [ADDR_W-1:0] data_idx_s;
  logic              mmio_sel_s;
  logic              data_wr_s;
  logic              ram_wr_s;
  logic              timer_wr_s;
  logic              led_wr_s;
  logic              num_wr_s;
  logic [31:0]       reg_rdata_s;
  logic [31:0]       led_merged_s;
  logic              unused_s;

  // Address decode, register-window read mux and write strobes.
  always_comb begin
    inst_idx_s   = sram.inst_sram_addr[ADDR_W+1:2];
    data_idx_s   = sram.data_sram_addr[ADDR_W+1:2];
    mmio_sel_s   = (sram.data_sram_addr[31:16] == MMIO_HI);
    data_wr_s    = sram.data_sram_en && (sram.data_sram_we != 4'h0);
    ram_wr_s     = data_wr_s && !mmio_sel_s;
    timer_wr_s   = 1'b0;
    led_wr_s     = 1'b0;
    num_wr_s     = 1'b0;
    reg_rdata_s  = 32'h0000_0000;
    led_merged_s = merge_lanes({16'h0000, led_r}, sram.data_sram_wdata, sram.data_sram_we);
    case (sram.data_sram_addr[15:0])
      OFF_TIMER: begin
        reg_rdata_s = timer_r;
        timer_wr_s  = data_wr_s && mmio_sel_s;
      end
      OFF_LED: begin
        reg_rdata_s = {16'h0000, led_r};
        led_wr_s    = data_wr_s && mmio_sel_s;
      end
      OFF_NUM: begin
        reg_rdata_s = num_r;
        num_wr_s    = data_wr_s && mmio_sel_s;
      end
      default: begin
        reg_rdata_s = 32'h0000_0000;
      end
    endcase
  end

  // RAM array: byte-lane writes from the data port, contents never reset.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (sram.data_sram_we[i]) mem_r[data_idx_s][8*i +: 8] <= sram.data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read-first data registers; non-blocking reads see the pre-edge contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata_r <= 32'h0000_0000;
      data_rdata_r <= 32'h0000_0000;
    end else begin
      if (sram.inst_sram_en) inst_rdata_r <= mem_r[inst_idx_s];
      if (sram.data_sram_en) data_rdata_r <= mmio_sel_s ? reg_rdata_s : mem_r[data_idx_s];
    end
  end

  // Register window: a timer write replaces that edge's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_r <= 32'h0000_0000;
      led_r   <= 16'h0000;
      num_r   <= 32'h0000_0000;
    end else begin
      timer_r <= timer_wr_s ? merge_lanes(timer_r, sram.data_sram_wdata, sram.data_sram_we)
                            : timer_r + 32'd1;
      if (led_wr_s) led_r <= led_merged_s[15:0];
      if (num_wr_s) num_r <= merge_lanes(num_r, sram.data_sram_wdata, sram.data_sram_we);
    end
  end

  assign sram.inst_sram_rdata = inst_rdata_r;
  assign sram.data_sram_rdata = data_rdata_r;
  assign led_o   = led_r;
  assign num_o   = num_r;
  assign timer_o = timer_r;

  // The instruction port is read-only and both ports are word-addressed.
  assign unused_s = ^{sram.inst_sram_we, sram.inst_sram_wdata, sram.inst_sram_addr,
                      sram.data_sram_addr[1:0], led_merged_s[31:16]};

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder: RAM, byte lanes,
// read-first collisions, aliasing, register window and async reset.
module tb_sram_responder;

  logic        clk;
  logic        resetn;
  logic [15:0] led_o;
  logic [31:0] num_o;
  logic [31:0] timer_o;
  int          pass_cnt;
  int          total_cnt;

  sram_responder_if bus();

  sram_responder #(.ADDR_W(16), .MMIO_HI(16'hBFAF)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .sram    (bus.slave),
    .led_o   (led_o),
    .num_o   (num_o),
    .timer_o (timer_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and land 1 time unit after it for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_we    = 4'h0;
    bus.inst_sram_addr  = 32'h0000_0000;
    bus.inst_sram_wdata = 32'h0000_0000;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 4'h0;
    bus.data_sram_addr  = 32'h0000_0000;
    bus.data_sram_wdata = 32'h0000_0000;
  endtask

  task automatic data_drive(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.inst_sram_rdata !== 32'h0) $display("FAIL reset_inst_rdata: got %h expected %h", bus.inst_sram_rdata, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.data_sram_rdata !== 32'h0) $display("FAIL reset_data_rdata: got %h expected %h", bus.data_sram_rdata, 32'h0); else pass_cnt++;
    total_cnt++; if (led_o !== 16'h0) $display("FAIL reset_led: got %h expected %h", led_o, 16'h0); else pass_cnt++;
    total_cnt++; if (num_o !== 32'h0) $display("FAIL reset_num: got %h expected %h", num_o, 32'h0); else pass_cnt++;
    total_cnt++; if (timer_o !== 32'h0) $display("FAIL reset_timer: got %h expected %h", timer_o, 32'h0); else pass_cnt++;
    resetn = 1'b1;
    tick();
    total_cnt++; if (timer_o !== 32'h1) $display("FAIL reset_timer_first_edge: got %h expected %h", timer_o, 32'h1); else pass_cnt++;
  endtask

  task automatic test_word_rw();
    data_drive(4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    data_drive(4'h0, 32'h0000_0100, 32'h0);
    tick();
    idle();
    total_cnt++; if (bus.data_sram_rdata !== 32'hDEAD_BEEF) $display("FAIL word_rw: got %h expected %h", bus.data_sram_rdata, 32'hDEAD_BEEF); else pass_cnt++;
  endtask

  task automatic test_byte_lanes();
    data_drive(4'hF, 32'h0000_0200, 32'h1122_3344);
    tick();
    data_drive(4'b0101, 32'h0000_0200, 32'hAABB_CCDD);
    tick();
    total_cnt++; if (bus.data_sram_rdata !== 32'h1122_3344) $display("FAIL byte_lanes_read_first: got %h expected %h", bus.data_sram_rdata, 32'h1122_3344); else pass_cnt++;
    data_drive(4'h0, 32'h0000_0200, 32'h0);
    tick();
    idle();
    total_cnt++; if (bus.data_sram_rdata !== 32'h11BB_33DD) $display("FAIL byte_lanes: got %h expected %h", bus.data_sram_rdata, 32'h11BB_33DD); else pass_cnt++;
  endtask

  task automatic test_collision();
    data_drive(4'hF, 32'h0000_0300, 32'h0000_0001);
    tick();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h0000_0300;
    data_drive(4'hF, 32'h0000_0300, 32'h0000_0002);
    tick();
    total_cnt++; if (bus.inst_sram_rdata !== 32'h0000_0001) $display("FAIL collision_old: got %h expected %h", bus.inst_sram_rdata, 32'h0000_0001); else pass_cnt++;
    bus.data_sram_en = 1'b0;
    tick();
    idle();
    total_cnt++; if (bus.inst_sram_rdata !== 32'h0000_0002) $display("FAIL collision_new: got %h expected %h", bus.inst_sram_rdata, 32'h0000_0002); else pass_cnt++;
  endtask

  task automatic test_alias_hold();
    data_drive(4'hF, 32'h0004_0000, 32'hCAFE_F00D);
    tick();
    data_drive(4'h0, 32'h0000_0000, 32'h0);
    tick();
    total_cnt++; if (bus.data_sram_rdata !== 32'hCAFE_F00D) $display("FAIL alias_read: got %h expected %h", bus.data_sram_rdata, 32'hCAFE_F00D); else pass_cnt++;
    idle();
    bus.data_sram_addr = 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++; if (bus.data_sram_rdata !== 32'hCAFE_F00D) $display("FAIL hold_cycle_%0d: got %h expected %h", k, bus.data_sram_rdata, 32'hCAFE_F00D); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin
      data_drive(4'hF, 32'h0000_0400 + 32'(4 * k), 32'hA000_0000 + 32'(k));
      tick();
      total_cnt++; if (bus.inst_sram_rdata !== 32'hDEAD_BEEF) $display("FAIL b2b_inst_%0d: got %h expected %h", k, bus.inst_sram_rdata, 32'hDEAD_BEEF); else pass_cnt++;
    end
    for (int k = 0; k < 4; k++) begin
      data_drive(4'h0, 32'h0000_0400 + 32'(4 * k), 32'h0);
      tick();
      total_cnt++; if (bus.data_sram_rdata !== 32'hA000_0000 + 32'(k)) $display("FAIL b2b_data_%0d: got %h expected %h", k, bus.data_sram_rdata, 32'hA000_0000 + 32'(k)); else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_mmio();
    data_drive(4'hF, 32'hBFAF_F000, 32'h1234_ABCD);
    tick();
    total_cnt++; if (led_o !== 16'hABCD) $display("FAIL led_write: got %h expected %h", led_o, 16'hABCD); else pass_cnt++;
    total_cnt++; if (bus.data_sram_rdata !== 32'h0) $display("FAIL led_read_first: got %h expected %h", bus.data_sram_rdata, 32'h0); else pass_cnt++;
    data_drive(4'h0, 32'hBFAF_F000, 32'h0);
    tick();
    total_cnt++; if (bus.data_sram_rdata !== 32'h0000_ABCD) $display("FAIL led_read: got %h expected %h", bus.data_sram_rdata, 32'h0000_ABCD); else pass_cnt++;
    data_drive(4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
    tick();
    total_cnt++; if (timer_o !== 32'hFFFF_FFFE) $display("FAIL timer_load: got %h expected %h", timer_o, 32'hFFFF_FFFE); else pass_cnt++;
    bus.data_sram_en = 1'b0;
    tick();
    total_cnt++; if (timer_o !== 32'hFFFF_FFFF) $display("FAIL timer_inc: got %h expected %h", timer_o, 32'hFFFF_FFFF); else pass_cnt++;
    data_drive(4'h0, 32'hBFAF_E000, 32'h0);
    tick();
    total_cnt++; if (timer_o !== 32'h0) $display("FAIL timer_wrap: got %h expected %h", timer_o, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.data_sram_rdata !== 32'hFFFF_FFFF) $display("FAIL timer_read_old: got %h expected %h", bus.data_sram_rdata, 32'hFFFF_FFFF); else pass_cnt++;
    data_drive(4'h0, 32'hBFAF_0004, 32'h0);
    tick();
    total_cnt++; if (bus.data_sram_rdata !== 32'h0) $display("FAIL mmio_unmapped: got %h expected %h", bus.data_sram_rdata, 32'h0); else pass_cnt++;
    data_drive(4'hF, 32'hBFAF_F010, 32'h0000_0005);
    tick();
    data_drive(4'h0, 32'hBFAF_F010, 32'h0);
    tick();
    idle();
    total_cnt++; if (num_o !== 32'h5) $display("FAIL num_write: got %h expected %h", num_o, 32'h5); else pass_cnt++;
    total_cnt++; if (bus.data_sram_rdata !== 32'h5) $display("FAIL num_read: got %h expected %h", bus.data_sram_rdata, 32'h5); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    #3;
    resetn = 1'b0;
    #1;
    total_cnt++; if (led_o !== 16'h0) $display("FAIL async_led: got %h expected %h", led_o, 16'h0); else pass_cnt++;
    total_cnt++; if (num_o !== 32'h0) $display("FAIL async_num: got %h expected %h", num_o, 32'h0); else pass_cnt++;
    total_cnt++; if (timer_o !== 32'h0) $display("FAIL async_timer: got %h expected %h", timer_o, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.inst_sram_rdata !== 32'h0) $display("FAIL async_inst_rdata: got %h expected %h", bus.inst_sram_rdata, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.data_sram_rdata !== 32'h0) $display("FAIL async_data_rdata: got %h expected %h", bus.data_sram_rdata, 32'h0); else pass_cnt++;
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    resetn    = 1'b0;
    idle();
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_collision();
    test_alias_hold();
    test_back_to_back();
    test_mmio();
    test_async_reset();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Responder for the CPU's instruction and data SRAM ports. It is a single-cycle-latency unified RAM with byte-lane writes, plus a small memory-mapped register window (timer, LED, number display) on the data port. It sits outside `mycpu_top` in the SoC/bench and answers every access issued on `inst_sram_*` and `data_sram_*`.

## Interface
- `ADDR_W`, 16: RAM word-index width; RAM depth is 2^ADDR_W 32-bit words.
- `MMIO_HI`, 16'hBFAF: value of data address bits [31:16] that selects the register window.
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `inst_sram_en` input 1: instruction read request.
- `inst_sram_we` input 4: ignored; the instruction port is read-only.
- `inst_sram_addr` input 32: byte address; bits [1:0] ignored.
- `inst_sram_wdata` input 32: ignored.
- `inst_sram_rdata` output 32: registered read data.
- `data_sram_en` input 1: data access request.
- `data_sram_we` input 4: byte-lane write enables; lane i covers bits [8i+7:8i].
- `data_sram_addr` input 32: byte address; bits [1:0] ignored.
- `data_sram_wdata` input 32: write data.
- `data_sram_rdata` output 32: registered read data.
- `led_o` output 16: LED register.
- `num_o` output 32: number-display register.
- `timer_o` output 32: free-running timer value.

## Operation
- RAM index is `addr[ADDR_W+1:2]`.
  - Upper bits are not decoded, so addresses alias modulo 2^(ADDR_W+2) bytes.
  - The instruction port always targets RAM, regardless of `MMIO_HI`.
- Data port decode: `data_sram_addr[31:16]==MMIO_HI` selects the register window. Any other address selects RAM.
- Register window offsets, from `addr[15:0]`:
  - 16'hE000 TIMER: read/write.
  - 16'hF000 LED: read/write, bits [15:0]; reads return the upper 16 bits as zero.
  - 16'hF010 NUM: read/write.
  - Any other offset reads 0; writes to it are ignored.
- Byte lanes apply to RAM and to register writes. Only the enabled lanes of the target word or register change.
- Read-first semantics on every port:
  - A data access with `we!=0` returns the old word on `data_sram_rdata`.
  - An instruction read of the word the data port writes in the same cycle returns the old word.
- TIMER:
  - Increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
  - A write in cycle N loads the merged value at edge N. Incrementing resumes from that value on the next edge; there is no +1 in the write cycle.
- `en=0`: no access. `rdata` holds its previous value.
- RAM contents are not reset. The bench preloads them via hierarchical `$readmemh` as needed.

## Timing
- Read latency is 1 cycle: request sampled at edge N, `rdata` valid after edge N and until the next edge with `en=1`.
- No stall or backpressure. Every cycle with `en=1` is accepted.
- Writes take effect at the sampling edge. A read of the same word in the next cycle returns the new data.
- The two ports are fully independent and may both be active in every cycle.
- Reset values:
  - `inst_sram_rdata`, `data_sram_rdata`: 0.
  - `led_o`: 16'h0000.
  - `num_o`: 0.
  - `timer_o`: 0.
- Reset asserted mid-operation:
  - Outputs and registers clear immediately, without waiting for a clock edge.
  - Writes in flight at that edge are dropped for registers.
  - RAM may or may not take the write in that cycle; the bench does not check it.
  - After `resetn` rises, TIMER counts from 0 at the first edge.
- Register-window reads return the value before any same-edge write or increment. A TIMER read at edge N returns the count held before edge N.

## Test plan
- Word write then read:
  - Stimulus: data write `we=4'hF`, addr 0x0000_0100, wdata 0xDEAD_BEEF; next cycle data read of the same address.
  - Required: `data_sram_rdata=0xDEAD_BEEF` one cycle after the read request.
- Byte lanes:
  - Stimulus: preload 0x1122_3344 at addr 0x200; write `we=4'b0101`, wdata 0xAABB_CCDD; then read addr 0x200.
  - Required: read returns 0x11BB_33DD.
- Read-first collision:
  - Stimulus: word at 0x300 = 0x0000_0001. In one cycle, instruction read of 0x300 and data write 0x0000_0002 to 0x300.
  - Required: `inst_sram_rdata=0x0000_0001`; a following instruction read returns 0x0000_0002.
- Aliasing and hold:
  - Stimulus: with ADDR_W=16, write 0xCAFE_F00D at 0x0004_0000; read 0x0000_0000; then hold `en=0` for 3 cycles.
  - Required: read returns 0xCAFE_F00D, and `rdata` is unchanged during the `en=0` cycles.
- MMIO:
  - Write 0x1234_ABCD to 0xBFAF_F000: `led_o=0xABCD` and a read returns 0x0000_ABCD.
  - Write 0xFFFF_FFFE to 0xBFAF_E000: `timer_o` shows 0xFFFF_FFFF one edge later, then 0.
  - Read 0xBFAF_0004: returns 0.
- Async reset:
  - Stimulus: drive `resetn` low between edges after `led_o=0xABCD` and `num_o=5`.
  - Required: `led_o`, `num_o`, `timer_o` and both `rdata` outputs read 0 before the next clock edge.
